// File: rtl/latch_exerciser.sv
// latch_exerciser
//   Stimulus generator and checker for a WIDTH-bit transparent latch with
//   asynchronous set/clear. One accepted start runs four fixed-control phases
//   (STEPS_FIXED steps each) and one random phase (STEPS_RAND steps). Each
//   step's drive is compared one clock later against a golden latch model.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle run request (ignored while busy)
//   q_in      : latch output read back
//   lat_aset  : latch async set (active high)
//   lat_aclr  : latch async clear (active high)
//   lat_gate  : latch enable (transparent when 1)
//   lat_data  : latch data input
//   busy      : sequence running
//   done      : sequence finished, held until next accepted start or reset
//   pass      : valid with done; 1 iff err_cnt == 0
//   err_cnt   : saturating mismatch count
module latch_exerciser #(
  parameter int          WIDTH       = 4,
  parameter int          STEPS_FIXED = 20,
  parameter int          STEPS_RAND  = 50,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] q_in,
  output logic             lat_aset,
  output logic             lat_aclr,
  output logic             lat_gate,
  output logic [WIDTH-1:0] lat_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic [7:0]  LAST_FIXED = 8'(STEPS_FIXED - 1);
  localparam logic [7:0]  LAST_RAND  = 8'(STEPS_RAND - 1);

  state_t           r_state;
  logic [2:0]       r_phase;
  logic [7:0]       r_step;
  logic [15:0]      r_lfsr;
  logic [WIDTH-1:0] r_exp;

  logic [15:0]      w_lfsr_next;
  logic [WIDTH-1:0] w_exp_next;
  logic             w_mismatch;
  logic [7:0]       w_err_next;
  logic             w_phase_end;
  logic             w_last_step;
  logic [2:0]       w_phase_nxt;
  logic [7:0]       w_step_nxt;
  logic [1:0]       w_ctl_nxt;
  logic [1:0]       w_ctl_first;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    lfsr_adv = {1'b0, x[15:1]} ^ (x[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Returns {aclr, aset} for a phase; the random phase takes them from the LFSR.
  function automatic logic [1:0] phase_ctl(input logic [2:0] ph, input logic [15:0] l);
    case (ph)
      3'd0:    phase_ctl = 2'b11;
      3'd1:    phase_ctl = 2'b10;
      3'd2:    phase_ctl = 2'b01;
      3'd3:    phase_ctl = 2'b00;
      default: phase_ctl = {l[13], l[14]};
    endcase
  endfunction

  always_comb begin
    w_lfsr_next = lfsr_adv(r_lfsr);

    // Golden latch response to the values currently on the outputs.
    w_exp_next = r_exp;
    if (lat_aclr)      w_exp_next = '0;
    else if (lat_aset) w_exp_next = '1;
    else if (lat_gate) w_exp_next = lat_data;

    w_mismatch = (q_in != w_exp_next);
    w_err_next = err_cnt;
    if (w_mismatch && (err_cnt != 8'hFF)) w_err_next = err_cnt + 8'd1;

    w_phase_end = (r_phase == 3'd4) ? (r_step == LAST_RAND) : (r_step == LAST_FIXED);
    w_last_step = (r_phase == 3'd4) && (r_step == LAST_RAND);
    w_phase_nxt = w_phase_end ? (r_phase + 3'd1) : r_phase;
    w_step_nxt  = w_phase_end ? '0 : (r_step + 8'd1);
    w_ctl_nxt   = phase_ctl(w_phase_nxt, r_lfsr);
    w_ctl_first = phase_ctl(3'd0, SEED_EFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_step   <= '0;
      r_lfsr   <= SEED_EFF;
      r_exp    <= '0;
      lat_aclr <= 1'b1;
      lat_aset <= 1'b0;
      lat_gate <= 1'b0;
      lat_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Step 0 is driven straight from the seed; the register then
            // holds the value for step 1.
            r_state  <= S_RUN;
            r_phase  <= '0;
            r_step   <= '0;
            r_lfsr   <= lfsr_adv(SEED_EFF);
            r_exp    <= '0;
            lat_aclr <= w_ctl_first[1];
            lat_aset <= w_ctl_first[0];
            lat_gate <= SEED_EFF[15];
            lat_data <= SEED_EFF[WIDTH-1:0];
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_exp   <= w_exp_next;
          err_cnt <= w_err_next;
          if (w_last_step) begin
            r_state  <= S_DONE;
            lat_aclr <= 1'b0;
            lat_aset <= 1'b0;
            lat_gate <= 1'b0;
            lat_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (w_err_next == 8'd0);
          end else begin
            r_phase  <= w_phase_nxt;
            r_step   <= w_step_nxt;
            r_lfsr   <= w_lfsr_next;
            lat_aclr <= w_ctl_nxt[1];
            lat_aset <= w_ctl_nxt[0];
            lat_gate <= r_lfsr[15];
            lat_data <= r_lfsr[WIDTH-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_exerciser.sv
module tb_latch_exerciser;
  localparam int W = 4;
  localparam int N = 130;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] q_in;
  logic         lat_aset, lat_aclr, lat_gate;
  logic [W-1:0] lat_data;
  logic         busy, done, pass;
  logic [7:0]   err_cnt;

  int errors = 0;
  int checks = 0;
  int fault_mode = 0;   // 0 good latch, 1 aset beats aclr, 2 q[0] stuck at 0

  always #5 clk = ~clk;

  latch_exerciser #(.WIDTH(W), .STEPS_FIXED(20), .STEPS_RAND(50), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_in),
    .lat_aset(lat_aset), .lat_aclr(lat_aclr), .lat_gate(lat_gate), .lat_data(lat_data),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  // Latch under test, with optional planted faults.
  logic [W-1:0] lq;
  always_latch begin
    if (fault_mode == 1 && lat_aset) lq <= '1;
    else if (lat_aclr)               lq <= '0;
    else if (lat_aset)               lq <= '1;
    else if (lat_gate)               lq <= lat_data;
  end
  assign q_in = (fault_mode == 2) ? {lq[W-1:1], 1'b0} : lq;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Reference trace for one run, built from the stated rules.
  logic         s_aclr [N];
  logic         s_aset [N];
  logic         s_gate [N];
  logic [W-1:0] s_data [N];
  int           pre    [N+1];  // mismatches among steps < k

  task automatic build(input int fm);
    logic [15:0]  l;
    logic [W-1:0] g, f, obs;
    int           p;
    l = 16'hACE1; g = '0; f = '0; pre[0] = 0;
    for (int k = 0; k < N; k++) begin
      p = (k < 80) ? k / 20 : 4;
      case (p)
        0: begin s_aclr[k] = 1; s_aset[k] = 1; end
        1: begin s_aclr[k] = 1; s_aset[k] = 0; end
        2: begin s_aclr[k] = 0; s_aset[k] = 1; end
        3: begin s_aclr[k] = 0; s_aset[k] = 0; end
        default: begin s_aclr[k] = l[13]; s_aset[k] = l[14]; end
      endcase
      s_gate[k] = l[15];
      s_data[k] = l[W-1:0];
      if (s_aclr[k]) g = '0; else if (s_aset[k]) g = '1; else if (s_gate[k]) g = s_data[k];
      if (fm == 1 && s_aset[k]) f = '1;
      else if (s_aclr[k]) f = '0; else if (s_aset[k]) f = '1; else if (s_gate[k]) f = s_data[k];
      obs = (fm == 2) ? (f & 4'hE) : f;
      pre[k+1] = pre[k] + ((obs != g) ? 1 : 0);
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  // Run-relative model: mode 0 idle, 1 running at step m_k, 2 done.
  int m_mode = 0;
  int m_k = 0;
  int m_final = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_k <= 0;
    end else if (m_mode == 1) begin
      if (m_k == N - 1) begin m_mode <= 2; m_final <= pre[N]; end
      else m_k <= m_k + 1;
    end else if (start) begin
      m_mode <= 1; m_k <= 0;
    end
  end

  function automatic int sat(input int v);
    sat = (v > 255) ? 255 : v;
  endfunction

  function automatic int pack(input logic ac, input logic as, input logic gt, input logic [W-1:0] d,
                              input logic b, input logic dn, input logic ps, input logic [7:0] e);
    pack = int'({ac, as, gt, d, b, dn, ps, e});
  endfunction

  always @(negedge clk) begin
    int expv;
    case (m_mode)
      0:       expv = pack(1, 0, 0, '0, 0, 0, 0, '0);
      1:       expv = pack(s_aclr[m_k], s_aset[m_k], s_gate[m_k], s_data[m_k], 1, 0, 0, 8'(sat(pre[m_k])));
      default: expv = pack(0, 0, 0, '0, 0, 1, (m_final == 0), 8'(sat(m_final)));
    endcase
    chk("cycle_outputs", pack(lat_aclr, lat_aset, lat_gate, lat_data, busy, done, pass, err_cnt), expv);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Waits for done while counting busy cycles; optionally raises start for
  // one cycle at loop index ra (sampled at edge E(ra+1)).
  task automatic run_wait(input int ra, output int nbusy, output bit ok);
    nbusy = 0; ok = 0;
    for (int i = 0; i < 1000; i++) begin
      start = (i == ra);
      if (busy) nbusy++;
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_aclr"}, lat_aclr, 1);
    chk({tag, "_aset_gate_data"}, {lat_aset, lat_gate, lat_data}, 0);
    chk({tag, "_busy_done_pass"}, {busy, done, pass}, 0);
    chk({tag, "_err"}, err_cnt, 0);
  endtask

  initial begin
    int  nb;
    bit  ok;

    build(0);
    chk("model_s0_data", s_data[0], 1);
    chk("model_s1_lfsr", {s_gate[1], s_data[1]}, 5'h10);
    chk("model_good_pre", pre[N], 0);

    repeat (3) @(negedge clk);
    reset_checks("reset");
    #1 rst_n = 1'b1;

    // Good latch.
    pulse_start();
    chk("step0_ctl", {lat_aclr, lat_aset, lat_gate}, 3'b111);
    chk("step0_data", lat_data, 1);
    run_wait(-1, nb, ok);
    chk("good_done_seen", ok, 1);
    chk("good_busy_cycles", nb, N);
    chk("good_pass", pass, 1);
    chk("good_err", err_cnt, 0);

    // Aset overrides Aclr.
    @(negedge clk); fault_mode = 1; build(1);
    pulse_start();
    run_wait(-1, nb, ok);
    chk("f1_done_seen", ok, 1);
    chk("f1_err_ge20", (err_cnt >= 20), 1);
    chk("f1_pass", pass, 0);

    // q[0] stuck at 0.
    @(negedge clk); fault_mode = 2; build(2);
    pulse_start();
    run_wait(-1, nb, ok);
    chk("f2_done_seen", ok, 1);
    chk("f2_err_ge20", (err_cnt >= 20), 1);
    chk("f2_pass", pass, 0);

    // Restart attempt mid-run is ignored.
    @(negedge clk); fault_mode = 0; build(0);
    pulse_start();
    run_wait(50, nb, ok);
    chk("restart_ignored_cycles", nb, N);
    chk("restart_pass", pass, 1);

    // Start sampled at the final edge is ignored.
    pulse_start();
    run_wait(N - 1, nb, ok);
    chk("lastedge_cycles", nb, N);
    @(negedge clk);
    chk("lastedge_done_held", {busy, done}, 2'b01);

    // Rerun from DONE; cycle checks pin the trace to the same reference.
    pulse_start();
    chk("rerun_step0_data", lat_data, 1);
    run_wait(-1, nb, ok);
    chk("rerun_cycles", nb, N);

    // Asynchronous reset mid-run.
    pulse_start();
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks("midrun_reset");
    @(negedge clk); #1 rst_n = 1'b1;
    pulse_start();
    run_wait(-1, nb, ok);
    chk("after_reset_cycles", nb, N);
    chk("after_reset_pass", pass, 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/latch_exerciser.md
# latch_exerciser

Synthesizable stimulus generator and checker for the 4-bit transparent latch with asynchronous set/clear, `Latch`. It drives the latch's `Aset`, `data`, `gate` and `Aclr` inputs in four fixed-control phases followed by one fully random phase. It reads the latch output back and compares it every step against an internal golden model. It sits beside the latch in board-level self-test: one `start` pulse runs the sequence and reports `pass` and an error count.

## Interface
- `WIDTH`, default 4: latch data width. Legal range is 1..12.
- `STEPS_FIXED`, default 20: number of steps in each of phases 0–3. Legal range is 1..255.
- `STEPS_RAND`, default 50: number of steps in phase 4. Legal range is 1..255.
- `SEED`, default 16'hACE1: LFSR seed. A value of 0 is replaced by 16'h0001.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to run the sequence.
- `q_in` in WIDTH: latch output `q`, read back.
- `lat_aset` out 1: latch asynchronous set, active-high.
- `lat_aclr` out 1: latch asynchronous clear, active-high.
- `lat_gate` out 1: latch enable, transparent when 1.
- `lat_data` out WIDTH: latch data input.
- `busy` out 1: sequence running.
- `done` out 1: sequence finished. Holds until the next accepted `start` or reset.
- `pass` out 1: valid when `done`=1. Equals 1 iff `err_cnt`==0.
- `err_cnt` out 8: mismatch count, saturates at 255.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN: `start`=1.
  - DONE→RUN: `start`=1.
  - RUN→DONE: after the last step is checked.
  - `start` is ignored in RUN.
- Latch semantics modelled, in priority order:
  - `aclr`=1 → 0.
  - otherwise `aset`=1 → all ones.
  - otherwise `gate`=1 → `data`.
  - otherwise hold.
- Phases in RUN:
  - Phase 0: aclr=1, aset=1.
  - Phase 1: aclr=1, aset=0.
  - Phase 2: aclr=0, aset=1.
  - Phase 3: aclr=0, aset=0.
  - Phases 0–3 last STEPS_FIXED steps each. Phase 4 lasts STEPS_RAND steps, with aclr and aset random.
  - Total steps N = 4·STEPS_FIXED + STEPS_RAND, which is 130 with defaults.
- Randomness: 16-bit Galois LFSR with mask 16'hB400, advanced once per step.
  - `lat_data` = lfsr[WIDTH-1:0] in all phases.
  - `lat_gate` = lfsr[15] in all phases.
  - Phase 4 only: `lat_aset` = lfsr[14], `lat_aclr` = lfsr[13].
- The LFSR is reloaded with SEED on every accepted `start`, so every run produces an identical stimulus trace.
- Golden model register `exp`:
  - Reset to 0, and set to 0 on start.
  - Updated each step from that step's driven values using the priority rule above.
  - Phase 0 clears the latch, so the model is defined from step 0.
- Check: the latch is combinational from the driven outputs. `q_in` sampled at the end of step k is compared to `exp` after step k.
  - Any bit mismatch increments `err_cnt`, saturating at 255.
- Idle drive values:
  - IDLE: `lat_aclr`=1, all other `lat_*`=0, so the latch is held clear.
  - DONE: all `lat_*`=0, so the latch holds its final value.
- Accepted start:
  - Clears `err_cnt`, `done` and `pass`.
  - Resets the phase and step counters.

## Timing
- Reset values:
  - `lat_aclr`=1; `lat_aset`=`lat_gate`=0; `lat_data`=0.
  - `busy`=`done`=`pass`=0; `err_cnt`=0.
  - State IDLE.
- Reset takes effect immediately on `rst_n` low, including mid-run.
- Edge E0 samples `start`=1. From E0:
  - `busy`=1.
  - Step 0 values are driven on registered outputs for cycle 1.
- Step k is driven during cycle k+1. Its check occurs at edge E(k+1), and step k+1 is driven from the same edge, for one step per clock.
- At edge E(N):
  - Last check.
  - `busy`→0, `done`→1.
  - `pass` = (final `err_cnt`==0), including a mismatch detected at that edge.
  - `lat_*` → DONE values.
- Total run: N cycles of `busy`.
- A `start` at edge E(N) itself is ignored. A `start` in DONE restarts with the same timing as from IDLE.

## Test plan
- Reset: hold `rst_n`=0 → `lat_aclr`=1; `lat_aset`=`lat_gate`=`lat_data`=0; `busy`=`done`=`pass`=0; `err_cnt`=0.
- Correct latch, default parameters, `start` pulse → `busy` high for exactly 130 cycles, then `done`=1, `pass`=1, `err_cnt`=0.
- Faulty latch where `Aset` overrides `Aclr` → phase 0 mismatches all 20 steps (expected 0, got 4'hF) → `err_cnt`≥20, `pass`=0.
- `q_in[0]` stuck at 0 → phase 2 mismatches every step → `err_cnt`≥20, `pass`=0.
- `start` pulsed again at step 50 → ignored; `done` still rises at cycle 130. A second `start` in DONE → `lat_*` trace identical to the first run.
- `rst_n` pulsed low at step 60 → outputs return to reset values immediately; a subsequent `start` runs all 130 steps and ends with `pass`=1.
